dmio_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the data-memory/IO block. Accepts load/store requests from two masters (port 0: CPU data path, port 1: loader/debug master), grants one at a time, and drives the single memory/IO bus (address, write data, write strobe) for a fixed 3-state transaction. Returns read data and a one-cycle acknowledge to the winner, and keeps saturating per-port grant counters for bring-up.

---
 rtl/dmio_arbiter.sv | 136 +++++++++++++
 tb/tb_dmio_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmio_arbiter.sv
// Two-port arbiter and 3-state access sequencer for the data-memory/IO bus.
// Define DMIO_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module dmio_arbiter #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64,
  parameter int unsigned CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic          wr0_i,
  input  logic          wr1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          ack0_o,
  output logic          ack1_o,
  output logic [DW-1:0] rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_wr_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o,
  output logic [CW-1:0] gcnt0_o,
  output logic [CW-1:0] gcnt1_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e          state_q;
  logic            winner_q;
  logic            ack0_q, ack1_q;
  logic [DW-1:0]   rdata_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic            mem_wr_q;
  logic [CW-1:0]   gcnt0_q, gcnt1_q;

  logic            grant_vld;
  logic            grant_sel;
  logic            sel_wr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

`ifndef DMIO_ARB_FIXED_PRIO_EN
  // Last-granted port; resets to 1 so port 0 wins the first tie.
  logic            last_q;
`endif

  // Grant decision for the current IDLE cycle.
  always_comb begin
    grant_vld = req0_i | req1_i;
    grant_sel = req1_i;
    if (req0_i && req1_i) begin
`ifdef DMIO_ARB_FIXED_PRIO_EN
      grant_sel = 1'b0;
`else
      grant_sel = ~last_q;
`endif
    end
    sel_wr    = grant_sel ? wr1_i    : wr0_i;
    sel_addr  = grant_sel ? addr1_i  : addr0_i;
    sel_wdata = grant_sel ? wdata1_i : wdata0_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      winner_q    <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      gcnt0_q     <= '0;
      gcnt1_q     <= '0;
`ifndef DMIO_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            winner_q    <= grant_sel;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_wr_q    <= sel_wr;
            // Grant counters saturate rather than wrap.
            if (grant_sel) begin
              if (gcnt1_q != '1) gcnt1_q <= gcnt1_q + CW'(1);
            end else begin
              if (gcnt0_q != '1) gcnt0_q <= gcnt0_q + CW'(1);
            end
            state_q <= StAccess;
          end
        end
        StAccess: begin
          rdata_q  <= mem_rdata_i;
          mem_wr_q <= 1'b0;
          ack0_q   <= ~winner_q;
          ack1_q   <= winner_q;
          state_q  <= StDone;
        end
        StDone: begin
`ifndef DMIO_ARB_FIXED_PRIO_EN
          last_q  <= winner_q;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wr_o    = mem_wr_q;
  assign busy_o      = (state_q != StIdle);
  assign gcnt0_o     = gcnt0_q;
  assign gcnt1_o     = gcnt1_q;

  a_ack_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) !(ack0_o && ack1_o));
  a_wr_access:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 mem_wr_o |-> (state_q == StAccess));
  a_ack_done:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 (ack0_o || ack1_o) |-> (state_q == StDone));

endmodule

// File: tb/tb_dmio_arbiter.sv
// Scoreboard bench for dmio_arbiter: stimulus queues expected bus/ack items, a monitor checks them.
module tb_dmio_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, wr0, wr1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr, busy;
  logic [15:0] gcnt0, gcnt1;

  // Second instance with a narrow counter for the saturation check.
  logic        s_req0;
  logic        s_ack0, s_ack1, s_mem_wr, s_busy;
  logic [63:0] s_rdata, s_mem_addr, s_mem_wdata;
  logic [3:0]  s_gcnt0, s_gcnt1;

  always #5 clk = ~clk;

  // Memory model: 0x1000 returns 0xA5, anything else returns the inverted address.
  assign mem_rdata = (mem_addr == 64'h1000) ? 64'hA5 : ~mem_addr;

  dmio_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .req1_i(req1), .wr0_i(wr0), .wr1_i(wr1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata_o(rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wr_o(mem_wr),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .gcnt0_o(gcnt0), .gcnt1_o(gcnt1)
  );

  dmio_arbiter #(.AW(64), .DW(64), .CW(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(s_req0), .req1_i(1'b0), .wr0_i(1'b1), .wr1_i(1'b0),
    .addr0_i(64'h8), .addr1_i(64'h0), .wdata0_i(64'h77), .wdata1_i(64'h0),
    .ack0_o(s_ack0), .ack1_o(s_ack1), .rdata_o(s_rdata),
    .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata), .mem_wr_o(s_mem_wr),
    .mem_rdata_i(64'h0), .busy_o(s_busy), .gcnt0_o(s_gcnt0), .gcnt1_o(s_gcnt1)
  );

  typedef struct {logic [63:0] addr; logic [63:0] wdata; logic wr;} bus_t;
  typedef struct {logic port; logic [63:0] rdata;} ack_t;

  bus_t bus_q[$];
  ack_t ack_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic busy_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: the first busy cycle of a transaction is ACCESS; acks are popped against ack_q.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && !busy_prev) begin
        if (bus_q.size() == 0) flag("unexpected_access");
        else begin
          bus_t b;
          b = bus_q.pop_front();
          chk("mem_addr", mem_addr, b.addr);
          chk("mem_wdata", mem_wdata, b.wdata);
          chk("mem_wr", {63'd0, mem_wr}, {63'd0, b.wr});
        end
      end else if (mem_wr) begin
        flag("mem_wr_outside_access");
      end
      if (ack0 || ack1) begin
        chk("ack_coincident", {63'd0, ack0 & ack1}, 64'd0);
        if (ack_q.size() == 0) flag("unexpected_ack");
        else begin
          ack_t a;
          a = ack_q.pop_front();
          chk("ack_port", {63'd0, ack1}, {63'd0, a.port});
          chk("rdata", rdata, a.rdata);
        end
      end
    end
    busy_prev = rst_n ? busy : 1'b0;
  end

  task automatic push(input logic p, input logic w, input logic [63:0] a, input logic [63:0] d,
                      input logic [63:0] rd);
    bus_q.push_back('{addr: a, wdata: d, wr: w});
    ack_q.push_back('{port: p, rdata: rd});
  endtask

  task automatic run_txn(input logic p, input logic w, input logic [63:0] a, input logic [63:0] d);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (p) begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (p ? ack1 : ack0) begin got = 1'b1; break; end
    end
    if (!got) flag("txn_timeout");
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    int acks;
    bit got;
    rst_n = 1'b0;
    {req0, req1, wr0, wr1, s_req0} = '0;
    {addr0, addr1, wdata0, wdata1} = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_gcnt0", {48'd0, gcnt0}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    rst_n = 1'b1;

    // Single write from port 0.
    push(1'b0, 1'b1, 64'h10, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFEF);
    run_txn(1'b0, 1'b1, 64'h10, 64'hDEAD);
    chk("gcnt0_after_write", {48'd0, gcnt0}, 64'd1);

    // Single read from port 1 into the IO region.
    push(1'b1, 1'b0, 64'h1000, 64'h0, 64'hA5);
    run_txn(1'b1, 1'b0, 64'h1000, 64'h0);
    chk("gcnt1_after_read", {48'd0, gcnt1}, 64'd1);

    // Contention: both ports requesting continuously for six transactions.
    for (int i = 0; i < 6; i++) begin
`ifdef DMIO_ARB_FIXED_PRIO_EN
      push(1'b0, 1'b0, 64'h40, 64'h1111, 64'hFFFF_FFFF_FFFF_FFBF);
`else
      if (i % 2 == 0) push(1'b0, 1'b0, 64'h40, 64'h1111, 64'hFFFF_FFFF_FFFF_FFBF);
      else            push(1'b1, 1'b1, 64'h80, 64'hBEEF, 64'hFFFF_FFFF_FFFF_FF7F);
`endif
    end
    @(posedge clk); #1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 64'h40; wdata0 = 64'h1111;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 64'h80; wdata1 = 64'hBEEF;
    acks = 0;
    for (int i = 0; i < 60 && acks < 6; i++) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    if (acks < 6) flag("contention_timeout");
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
`ifdef DMIO_ARB_FIXED_PRIO_EN
    chk("gcnt0_contention", {48'd0, gcnt0}, 64'd7);
    chk("gcnt1_contention", {48'd0, gcnt1}, 64'd1);
`else
    chk("gcnt0_contention", {48'd0, gcnt0}, 64'd4);
    chk("gcnt1_contention", {48'd0, gcnt1}, 64'd4);
`endif

    // Reset in the middle of an ACCESS write: no ack, everything back to reset values.
    bus_q.push_back('{addr: 64'h30, wdata: 64'h5555, wr: 1'b1});
    @(posedge clk); #1;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 64'h30; wdata0 = 64'h5555;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_wr) begin got = 1'b1; break; end
    end
    if (!got) flag("reset_access_timeout");
    #2 rst_n = 1'b0;
    #1;
    req0 = 1'b0;
    chk("midrst_mem_wr", {63'd0, mem_wr}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_mem_addr", mem_addr, 64'd0);
    chk("midrst_mem_wdata", mem_wdata, 64'd0);
    chk("midrst_acks", {62'd0, ack1, ack0}, 64'd0);
    chk("midrst_gcnt0", {48'd0, gcnt0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
    chk("ack_q_drained", 64'(ack_q.size()), 64'd0);

    // Saturation on the CW=4 instance: 20 grants stop the counter at 15.
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      s_req0 = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (s_ack0) begin got = 1'b1; break; end
      end
      if (!got) flag("sat_timeout");
      @(posedge clk); #1;
      s_req0 = 1'b0;
      if (n == 14) chk("sat_gcnt0_at_15", {60'd0, s_gcnt0}, 64'd15);
    end
    @(negedge clk);
    chk("sat_gcnt0_final", {60'd0, s_gcnt0}, 64'd15);
    chk("sat_gcnt1", {60'd0, s_gcnt1}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
